// File: rtl/fill_ctrl.sv
// Bottle-fill sequencer: debounced buttons and hopper pulses drive set/run/change/alarm/done states.
// All outputs registered, one cycle after the synchronized event; no backpressure (free-running 1 kHz stage).
module fill_ctrl #(
  parameter int MAX_BOTTLES = 99,
  parameter int DEBOUNCE_MS = 20,
  parameter int CHANGE_MS   = 2000,
  parameter int STALL_MS    = 3000,
  parameter int BEEP_MS     = 1000
) (
  input  logic       clk_1khz,
  input  logic       clr,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic       hopper_signal,
  input  logic       conveyor_stop,
  output logic [3:0] display_1,
  output logic [3:0] display_2,
  output logic [3:0] display_3,
  output logic [3:0] display_4,
  output logic [3:0] display_5,
  output logic [3:0] display_6,
  output logic [5:0] flicker_mask,
  output logic [1:0] beep_mode,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_SET_TENS = 3'd0,
    S_SET_ONES = 3'd1,
    S_RUN      = 3'd2,
    S_PAUSE    = 3'd3,
    S_CHANGE   = 3'd4,
    S_ALARM    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int SW = $clog2(STALL_MS + 1);
  localparam int CW = $clog2(CHANGE_MS + 1);
  localparam int BW = $clog2(BEEP_MS + 1);
  localparam logic [7:0] MAX_BCD = {4'(MAX_BOTTLES / 10), 4'(MAX_BOTTLES % 10)};

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [3:0] dig_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  logic [1:0]    btn_s1_q, btn_s2_q, btn_deb_q;
  logic [DW-1:0] btn_cnt_q [2];
  logic [1:0]    press;
  logic [2:0]    hop_q;
  logic          item_edge;

  state_t        state_q, state_d;
  logic [7:0]    tgt_q, tgt_d, item_q, item_d, btl_q, btl_d, item_inc;
  logic [SW-1:0] stall_q, stall_d;
  logic [CW-1:0] chg_q, chg_d;
  logic [BW-1:0] beep_q, beep_d;
  logic [5:0]    mask_q, mask_d;
  logic [1:0]    beep_mode_q, beep_mode_d;

  // Level is accepted after DEBOUNCE_MS consecutive cycles of disagreement with the held level.
  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      btn_deb_q <= '0;
      hop_q     <= '0;
      for (int i = 0; i < 2; i++) btn_cnt_q[i] <= '0;
    end else begin
      btn_s1_q <= {btn_2, btn_1};
      btn_s2_q <= btn_s1_q;
      hop_q    <= {hop_q[1:0], hopper_signal};
      for (int i = 0; i < 2; i++) begin
        if (btn_s2_q[i] == btn_deb_q[i]) begin
          btn_cnt_q[i] <= '0;
        end else if (btn_cnt_q[i] == DW'(DEBOUNCE_MS - 1)) begin
          btn_deb_q[i] <= btn_s2_q[i];
          btn_cnt_q[i] <= '0;
        end else begin
          btn_cnt_q[i] <= btn_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press = '0;
    for (int i = 0; i < 2; i++)
      press[i] = btn_s2_q[i] & ~btn_deb_q[i] & (btn_cnt_q[i] == DW'(DEBOUNCE_MS - 1));
  end

  assign item_edge = hop_q[1] & ~hop_q[2];
  assign item_inc  = bcd_inc(item_q);

  always_ff @(posedge clk_1khz or posedge clr) begin
    if (clr) begin
      state_q     <= S_SET_TENS;
      tgt_q       <= '0;
      item_q      <= '0;
      btl_q       <= '0;
      stall_q     <= '0;
      chg_q       <= '0;
      beep_q      <= '0;
      mask_q      <= 6'b000001;
      beep_mode_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      item_q      <= item_d;
      btl_q       <= btl_d;
      stall_q     <= stall_d;
      chg_q       <= chg_d;
      beep_q      <= beep_d;
      mask_q      <= mask_d;
      beep_mode_q <= beep_mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    item_d  = item_q;
    btl_d   = btl_q;
    stall_d = stall_q;
    chg_d   = chg_q;
    beep_d  = (beep_q != '0) ? beep_q - 1'b1 : '0;
    unique case (state_q)
      S_SET_TENS: begin
        if (press[0]) tgt_d[7:4] = dig_inc(tgt_q[7:4]);
        if (press[1]) state_d = S_SET_ONES;
      end
      S_SET_ONES: begin
        if (press[0]) tgt_d[3:0] = dig_inc(tgt_q[3:0]);
        if (press[1] && tgt_q != 8'h00) begin
          state_d = S_RUN;
          stall_d = '0;
        end
      end
      S_RUN: begin
        // A target hit always comes with an edge, so it outranks the stall expiry.
        if (!conveyor_stop) begin
          if (item_edge) begin
            item_d  = item_inc;
            stall_d = '0;
            if (item_inc == tgt_q) begin
              btl_d   = (btl_q == MAX_BCD) ? btl_q : bcd_inc(btl_q);
              state_d = S_CHANGE;
              chg_d   = '0;
              beep_d  = BW'(BEEP_MS);
            end
          end else if (stall_q == SW'(STALL_MS - 1)) begin
            state_d = S_ALARM;
            stall_d = '0;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
        if (press[1] && state_d == S_RUN) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (press[1]) state_d = S_RUN;
      end
      S_CHANGE: begin
        if (!conveyor_stop) begin
          if (chg_q == CW'(CHANGE_MS - 1)) begin
            item_d  = '0;
            stall_d = '0;
            state_d = (btl_q == MAX_BCD) ? S_DONE : S_RUN;
          end else begin
            chg_d = chg_q + 1'b1;
          end
        end
      end
      S_ALARM: begin
        if (press[1]) begin
          state_d = S_RUN;
          stall_d = '0;
        end
      end
      S_DONE: begin
        if (press[1]) begin
          state_d = S_SET_TENS;
          item_d  = '0;
          btl_d   = '0;
        end
      end
      default: state_d = S_SET_TENS;
    endcase
  end

  always_comb begin
    mask_d      = 6'b000000;
    beep_mode_d = 2'd0;
    case (state_d)
      S_SET_TENS:       mask_d = 6'b000001;
      S_SET_ONES:       mask_d = 6'b000010;
      S_PAUSE, S_CHANGE: mask_d = 6'b001100;
      S_ALARM:          mask_d = 6'b111111;
      S_DONE:           mask_d = 6'b110000;
      default:          mask_d = 6'b000000;
    endcase
    if (state_d == S_ALARM)     beep_mode_d = 2'd3;
    else if (state_d == S_DONE) beep_mode_d = 2'd2;
    else if (beep_d != '0)      beep_mode_d = 2'd1;
  end

  assign display_1    = tgt_q[7:4];
  assign display_2    = tgt_q[3:0];
  assign display_3    = item_q[7:4];
  assign display_4    = item_q[3:0];
  assign display_5    = btl_q[7:4];
  assign display_6    = btl_q[3:0];
  assign flicker_mask = mask_q;
  assign beep_mode    = beep_mode_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_fill_ctrl.sv
// Directed bench for fill_ctrl: set target, count, change, stall alarm, done, reset-in-flight.
module tb_fill_ctrl;

  logic       clk_1khz = 1'b0;
  logic       clr, btn_1, btn_2, hopper_signal, conveyor_stop;
  logic [3:0] display_1, display_2, display_3, display_4, display_5, display_6;
  logic [5:0] flicker_mask;
  logic [1:0] beep_mode;
  logic [2:0] state_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_1khz = ~clk_1khz;

  fill_ctrl #(.MAX_BOTTLES(2)) dut (
    .clk_1khz(clk_1khz), .clr(clr), .btn_1(btn_1), .btn_2(btn_2),
    .hopper_signal(hopper_signal), .conveyor_stop(conveyor_stop),
    .display_1(display_1), .display_2(display_2), .display_3(display_3),
    .display_4(display_4), .display_5(display_5), .display_6(display_6),
    .flicker_mask(flicker_mask), .beep_mode(beep_mode), .state_o(state_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_1khz);
    #1;
  endtask

  task automatic press1();
    btn_1 = 1'b1; tick(30);
    btn_1 = 1'b0; tick(30);
  endtask

  task automatic press2();
    btn_2 = 1'b1; tick(30);
    btn_2 = 1'b0; tick(30);
  endtask

  task automatic hop();
    hopper_signal = 1'b1; tick(3);
    hopper_signal = 1'b0; tick(3);
  endtask

  task automatic do_reset();
    clr = 1'b1; btn_1 = 1'b0; btn_2 = 1'b0;
    hopper_signal = 1'b0; conveyor_stop = 1'b0;
    tick(3);
    clr = 1'b0;
    tick(2);
  endtask

  initial begin
    clr = 1'b1; btn_1 = 1'b0; btn_2 = 1'b0;
    hopper_signal = 1'b0; conveyor_stop = 1'b0;
    tick(3);
    chk("rst_state", state_o, 3'd0);
    chk("rst_mask", flicker_mask, 6'b000001);
    chk("rst_beep", beep_mode, 2'd0);
    chk("rst_disp", {display_1, display_2, display_3, display_4, display_5, display_6}, 24'h000000);
    clr = 1'b0;
    tick(2);

    // Target 35, with a short glitch that must not count
    press1(); press1(); press1();
    btn_1 = 1'b1; tick(5); btn_1 = 1'b0; tick(30);
    chk("glitch_tens", display_1, 4'd3);
    chk("tens_mask", flicker_mask, 6'b000001);
    press2();
    chk("ones_state", state_o, 3'd1);
    chk("ones_mask", flicker_mask, 6'b000010);
    press1(); press1(); press1(); press1(); press1();
    press2();
    chk("t35_target", {display_1, display_2}, 8'h35);
    chk("t35_state", state_o, 3'd2);
    chk("t35_mask", flicker_mask, 6'b000000);
    chk("t35_beep", beep_mode, 2'd0);

    hop();
    chk("item1", {display_3, display_4}, 8'h01);
    tick(2900);
    chk("pre_alarm_state", state_o, 3'd2);
    tick(150);
    chk("alarm_state", state_o, 3'd5);
    chk("alarm_mask", flicker_mask, 6'b111111);
    chk("alarm_beep", beep_mode, 2'd3);
    press2();
    chk("ack_state", state_o, 3'd2);
    chk("ack_items", {display_3, display_4, display_5, display_6}, 16'h0100);
    chk("ack_beep", beep_mode, 2'd0);

    press2();
    chk("pause_state", state_o, 3'd3);
    chk("pause_mask", flicker_mask, 6'b001100);
    hop();
    chk("pause_items", {display_3, display_4}, 8'h01);
    press2();
    chk("resume_state", state_o, 3'd2);
    conveyor_stop = 1'b1;
    hop();
    chk("stop_items", {display_3, display_4}, 8'h01);
    conveyor_stop = 1'b0;
    tick(2);

    // Target 02: completion beep, change timer frozen by conveyor_stop
    do_reset();
    press2(); press1(); press1(); press2();
    chk("t02_state", state_o, 3'd2);
    hop(); hop();
    chk("hit_counts", {display_3, display_4, display_5, display_6}, 16'h0201);
    chk("hit_state", state_o, 3'd4);
    chk("hit_mask", flicker_mask, 6'b001100);
    chk("hit_beep", beep_mode, 2'd1);
    tick(985);
    chk("beep_late", beep_mode, 2'd1);
    tick(25);
    chk("beep_over", beep_mode, 2'd0);
    conveyor_stop = 1'b1;
    tick(500);
    chk("frozen_state", state_o, 3'd4);
    conveyor_stop = 1'b0;
    tick(960);
    chk("chg_delayed_state", state_o, 3'd4);
    chk("chg_delayed_items", {display_3, display_4}, 8'h02);
    tick(50);
    chk("chg_exit_state", state_o, 3'd2);
    chk("chg_exit_counts", {display_3, display_4, display_5, display_6}, 16'h0001);

    // Target 01 with MAX_BOTTLES = 2; zero target rejected first
    do_reset();
    press2();
    press2();
    chk("zero_tgt_state", state_o, 3'd1);
    press1(); press2();
    chk("t01_state", state_o, 3'd2);
    hop();
    chk("b1_state", state_o, 3'd4);
    tick(2050);
    chk("b1_run", state_o, 3'd2);
    chk("b1_counts", {display_3, display_4, display_5, display_6}, 16'h0001);
    hop();
    chk("b2_counts", {display_5, display_6}, 8'h02);
    tick(2050);
    chk("done_state", state_o, 3'd6);
    chk("done_beep", beep_mode, 2'd2);
    chk("done_mask", flicker_mask, 6'b110000);
    chk("done_counts", {display_3, display_4, display_5, display_6}, 16'h0002);
    press2();
    chk("restart_state", state_o, 3'd0);
    chk("restart_disp", {display_1, display_2, display_3, display_4, display_5, display_6}, 24'h010000);
    chk("restart_mask", flicker_mask, 6'b000001);

    // Asynchronous clear in the middle of CHANGE
    do_reset();
    press2(); press1(); press2();
    hop();
    tick(100);
    chk("mid_chg_state", state_o, 3'd4);
    clr = 1'b1;
    #1;
    chk("clr_state", state_o, 3'd0);
    chk("clr_disp", {display_1, display_2, display_3, display_4, display_5, display_6}, 24'h000000);
    chk("clr_mask", flicker_mask, 6'b000001);
    chk("clr_beep", beep_mode, 2'd0);
    tick(5);
    chk("clr_hold_state", state_o, 3'd0);
    clr = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
